// File: rtl/dot_product_stream.sv
// dot_product_stream
//   Streaming dot-product engine. Two L-element vectors arrive as B = L/P
//   beats of P element pairs. Each beat is multiplied across P lanes
//   (stage 1), reduced to one ACC_W-wide sum (stage 2) and accumulated
//   (stage 3). One result per vector is held until the consumer takes it,
//   together with the number of edges the vector took.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         beat handshake (in_ready registered)
//   in_a, in_b [P*N]            lane i at [i*N +: N], element = beat*P + i
//   signed_mode                 operand signedness, sampled on beat 0
//   out_valid / out_ready       result handshake
//   out_result [ACC_W]          dot product (sign/zero extended)
//   out_cycles [16]             edges from first beat to result, saturating

// Per-lane multiplier: exact 2N-bit product in either signedness.
module dot_product_stream_lane #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic           i_signed,
    output logic [2*N-1:0] o_prod
);
    logic signed [2*N-1:0] w_ps;
    logic        [2*N-1:0] w_pu;

    assign w_ps   = $signed(i_a) * $signed(i_b);
    assign w_pu   = i_a * i_b;
    assign o_prod = i_signed ? w_ps : w_pu;
endmodule

module dot_product_stream #(
    parameter int N = 8,
    parameter int L = 16,
    parameter int P = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [P*N-1:0]                in_a,
    input  logic [P*N-1:0]                in_b,
    input  logic                          signed_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*N+$clog2(L)-1:0]      out_result,
    output logic [15:0]                   out_cycles
);
    localparam int ACC_W = 2*N + $clog2(L);
    localparam int B     = L / P;
    localparam int BW    = (B > 1) ? $clog2(B) : 1;
    localparam int EXT   = ACC_W - 2*N;

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t                  r_state, w_next_state;
    logic [BW-1:0]           r_beat;
    logic                    r_drain;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_smode;
    logic [15:0]             r_cyc;
    logic [15:0]             r_cycles;
    logic [ACC_W-1:0]        r_result;

    // r_vld_pipe[0] = stage 1 (products), r_vld_pipe[1] = stage 2 (sum)
    logic [1:0]              r_vld_pipe;
    logic [P-1:0][2*N-1:0]   r_s1_prod;
    logic                    r_s1_first, r_s1_last, r_s1_sm;
    logic [ACC_W-1:0]        r_s2_sum;
    logic                    r_s2_first, r_s2_last;
    logic [ACC_W-1:0]        r_acc;

    logic                    w_accept, w_first, w_last, w_smode;
    logic [P-1:0][2*N-1:0]   w_prod;
    logic [ACC_W-1:0]        w_sum;
    logic [ACC_W-1:0]        w_acc_next;
    logic [15:0]             w_cyc_inc;

    assign w_accept = in_valid && r_in_ready;
    assign w_first  = (r_beat == '0);
    assign w_last   = (r_beat == BW'(B-1));
    // Beat 0 uses the live pin; later beats use the value latched on beat 0.
    assign w_smode  = w_first ? signed_mode : r_smode;

    // ---------------- control FSM ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_accept && w_last) w_next_state = DRAIN;
            DRAIN:   if (r_drain)            w_next_state = HOLD;
            HOLD:    if (out_ready)          w_next_state = FILL;
            default:                         w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_beat      <= '0;
            r_drain     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_smode     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // in_ready/out_valid are registered copies of the next state
            r_in_ready  <= (w_next_state == FILL);
            r_out_valid <= (w_next_state == HOLD);
            // second DRAIN cycle is flagged so HOLD follows two edges after the last beat
            r_drain     <= (r_state == DRAIN);
            if (w_accept) begin
                r_beat <= w_last ? '0 : r_beat + BW'(1);
                if (w_first) r_smode <= signed_mode;
            end
        end
    end

    // ---------------- stage 1: lane multipliers ----------------
    for (genvar g = 0; g < P; g++) begin : g_lane
        dot_product_stream_lane #(.N(N)) u_lane (
            .i_a      (in_a[g*N +: N]),
            .i_b      (in_b[g*N +: N]),
            .i_signed (w_smode),
            .o_prod   (w_prod[g])
        );
    end

    // ---------------- stage 2: reduction ----------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < P; i++) begin
            if (r_s1_sm) w_sum = w_sum + {{EXT{r_s1_prod[i][2*N-1]}}, r_s1_prod[i]};
            else         w_sum = w_sum + {{EXT{1'b0}}, r_s1_prod[i]};
        end
    end

    // ---------------- stage 3: accumulate ----------------
    assign w_acc_next = r_s2_first ? r_s2_sum : r_acc + r_s2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1_prod  <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sm    <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_acc      <= '0;
            r_result   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_accept};
            r_s1_first <= w_accept && w_first;
            r_s1_last  <= w_accept && w_last;
            if (w_accept) begin
                r_s1_prod <= w_prod;
                r_s1_sm   <= w_smode;
            end
            r_s2_first <= r_vld_pipe[0] && r_s1_first;
            r_s2_last  <= r_vld_pipe[0] && r_s1_last;
            if (r_vld_pipe[0]) r_s2_sum <= w_sum;
            if (r_vld_pipe[1]) begin
                r_acc <= w_acc_next;
                if (r_s2_last) r_result <= w_acc_next;
            end
        end
    end

    // ---------------- latency counter ----------------
    assign w_cyc_inc = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc    <= '0;
            r_cycles <= '0;
        end else begin
            if (r_state == FILL && w_accept && w_first)
                r_cyc <= '0;
            else if (r_state == DRAIN || (r_state == FILL && !w_first))
                r_cyc <= w_cyc_inc;
            // the edge that raises out_valid is itself counted
            if (r_state == DRAIN && r_drain)
                r_cycles <= w_cyc_inc;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_cycles = r_cycles;
endmodule
